// File: rtl/fast_pat_load.sv
// Packs a 24-bit pixel stream into 256-bit memory words (32 pixels per 3 words) and
// publishes the frame via a header marker. Define FAST_PAT_LOAD_CLR_HDR_EN to clear the marker first.
module fast_pat_load #(
  parameter int unsigned FRAME_GROUPS = 60,
  parameter logic [10:0] BASE_ADDR    = 11'd1,
  parameter logic [10:0] HDR_ADDR     = 11'd0,
  parameter logic [7:0]  MARKER       = 8'h77
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_start,
  input  logic         load_abort,
  input  logic         pix_valid,
  input  logic [23:0]  pix_data,
  output logic         pix_ready,
  output logic         load_busy,
  output logic         load_done,
  output logic         onchip_mem_chip_select,
  output logic         onchip_mem_chip_read,
  output logic         onchip_mem_write,
  output logic [10:0]  onchip_mem_addr,
  output logic [31:0]  onchip_mem_byte_enable,
  output logic [255:0] onchip_mem_write_data
);

  localparam logic [9:0] LastGroup = 10'(FRAME_GROUPS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
`ifdef FAST_PAT_LOAD_CLR_HDR_EN
    StClrHdr = 3'd1,
`endif
    StFill   = 3'd2,
    StWrite  = 3'd3,
    StWrHdr  = 3'd4,
    StDone   = 3'd5
  } state_e;

  state_e      state_q;
  logic [4:0]  pix_cnt_q;
  logic [9:0]  grp_cnt_q;
  logic [10:0] wr_addr_q;
  logic [1:0]  wr_word_q;
  // Pixel 0 of a group only feeds the first data word, which is issued on the same edge
  // the 32nd pixel arrives, so 31 pixels of shift register suffice.
  logic [743:0] pack_q;
  logic         accept;

  assign accept               = pix_valid & pix_ready;
  assign onchip_mem_chip_read = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                <= StIdle;
      pix_cnt_q              <= '0;
      grp_cnt_q              <= '0;
      wr_addr_q              <= '0;
      wr_word_q              <= '0;
      pack_q                 <= '0;
      pix_ready              <= 1'b0;
      load_busy              <= 1'b0;
      load_done              <= 1'b0;
      onchip_mem_chip_select <= 1'b0;
      onchip_mem_write       <= 1'b0;
      onchip_mem_addr        <= '0;
      onchip_mem_byte_enable <= '0;
      onchip_mem_write_data  <= '0;
    end else begin
      load_done              <= 1'b0;
      onchip_mem_chip_select <= 1'b0;
      onchip_mem_write       <= 1'b0;
      onchip_mem_addr        <= '0;
      onchip_mem_byte_enable <= '0;
      onchip_mem_write_data  <= '0;
      if (load_abort) begin
        state_q   <= StIdle;
        pix_cnt_q <= '0;
        grp_cnt_q <= '0;
        wr_addr_q <= '0;
        wr_word_q <= '0;
        pix_ready <= 1'b0;
        load_busy <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (load_start) begin
              pix_cnt_q <= '0;
              grp_cnt_q <= '0;
              wr_addr_q <= BASE_ADDR;
              wr_word_q <= '0;
              load_busy <= 1'b1;
`ifdef FAST_PAT_LOAD_CLR_HDR_EN
              state_q                <= StClrHdr;
              onchip_mem_chip_select <= 1'b1;
              onchip_mem_write       <= 1'b1;
              onchip_mem_addr        <= HDR_ADDR;
              onchip_mem_byte_enable <= 32'h0000_0001;
`else
              state_q   <= StFill;
              pix_ready <= 1'b1;
`endif
            end
          end
`ifdef FAST_PAT_LOAD_CLR_HDR_EN
          StClrHdr: begin
            state_q   <= StFill;
            pix_ready <= 1'b1;
          end
`endif
          StFill: begin
            if (accept) begin
              pack_q    <= {pack_q[719:0], pix_data};
              pix_cnt_q <= pix_cnt_q + 5'd1;
              if (pix_cnt_q == 5'd31) begin
                state_q                <= StWrite;
                pix_ready              <= 1'b0;
                wr_word_q              <= 2'd0;
                onchip_mem_chip_select <= 1'b1;
                onchip_mem_write       <= 1'b1;
                onchip_mem_addr        <= wr_addr_q;
                onchip_mem_byte_enable <= 32'hFFFF_FFFF;
                onchip_mem_write_data  <= pack_q[743:488];
              end
            end
          end
          StWrite: begin
            // wr_word_q names the word currently on the bus.
            if (wr_word_q == 2'd0) begin
              wr_word_q              <= 2'd1;
              onchip_mem_chip_select <= 1'b1;
              onchip_mem_write       <= 1'b1;
              onchip_mem_addr        <= wr_addr_q + 11'd1;
              onchip_mem_byte_enable <= 32'hFFFF_FFFF;
              onchip_mem_write_data  <= pack_q[511:256];
            end else if (wr_word_q == 2'd1) begin
              wr_word_q              <= 2'd2;
              onchip_mem_chip_select <= 1'b1;
              onchip_mem_write       <= 1'b1;
              onchip_mem_addr        <= wr_addr_q + 11'd2;
              onchip_mem_byte_enable <= 32'hFFFF_FFFF;
              onchip_mem_write_data  <= pack_q[255:0];
            end else if (grp_cnt_q == LastGroup) begin
              state_q                <= StWrHdr;
              onchip_mem_chip_select <= 1'b1;
              onchip_mem_write       <= 1'b1;
              onchip_mem_addr        <= HDR_ADDR;
              onchip_mem_byte_enable <= 32'h0000_0001;
              onchip_mem_write_data  <= {248'h0, MARKER};
            end else begin
              state_q   <= StFill;
              grp_cnt_q <= grp_cnt_q + 10'd1;
              wr_addr_q <= wr_addr_q + 11'd3;
              pix_ready <= 1'b1;
            end
          end
          StWrHdr: begin
            state_q   <= StDone;
            load_done <= 1'b1;
          end
          StDone: begin
            state_q   <= StIdle;
            load_busy <= 1'b0;
            pix_cnt_q <= '0;
            grp_cnt_q <= '0;
            wr_addr_q <= '0;
            wr_word_q <= '0;
          end
          default: begin
            state_q   <= StIdle;
            load_busy <= 1'b0;
            pix_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fast_pat_load.sv
// Scoreboard bench for fast_pat_load: expected memory writes are queued as pixels are accepted.
module tb_fast_pat_load;

  localparam int unsigned Groups   = 60;
  localparam logic [10:0] BaseAddr = 11'd1;
  localparam logic [10:0] HdrAddr  = 11'd0;
  localparam logic [7:0]  Marker   = 8'h77;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_start, load_abort, pix_valid;
  logic [23:0]  pix_data;
  logic         pix_ready, load_busy, load_done;
  logic         mem_cs, mem_rd, mem_wr;
  logic [10:0]  mem_addr;
  logic [31:0]  mem_be;
  logic [255:0] mem_data;

  typedef struct packed {
    logic [10:0]  addr;
    logic [31:0]  be;
    logic [255:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0, failures = 0;
  int  cyc = 0, done_cnt = 0, last_data_cyc = -100, done_cyc = -100;

  always #5 clk = ~clk;

  fast_pat_load #(
    .FRAME_GROUPS(Groups),
    .BASE_ADDR   (BaseAddr),
    .HDR_ADDR    (HdrAddr),
    .MARKER      (Marker)
  ) u_dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .load_start            (load_start),
    .load_abort            (load_abort),
    .pix_valid             (pix_valid),
    .pix_data              (pix_data),
    .pix_ready             (pix_ready),
    .load_busy             (load_busy),
    .load_done             (load_done),
    .onchip_mem_chip_select(mem_cs),
    .onchip_mem_chip_read  (mem_rd),
    .onchip_mem_write      (mem_wr),
    .onchip_mem_addr       (mem_addr),
    .onchip_mem_byte_enable(mem_be),
    .onchip_mem_write_data (mem_data)
  );

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [10:0] addr, input logic [31:0] be, input logic [255:0] data);
    wr_t e;
    e.addr = addr;
    e.be   = be;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_rdy"}, pix_ready, 0);
    check_val({tag, "_busy"}, load_busy, 0);
    check_val({tag, "_done"}, load_done, 0);
    check_val({tag, "_cs"}, mem_cs, 0);
    check_val({tag, "_rd"}, mem_rd, 0);
    check_val({tag, "_wr"}, mem_wr, 0);
    check_val({tag, "_addr"}, mem_addr, 0);
    check_val({tag, "_be"}, mem_be, 0);
    check_val({tag, "_data"}, mem_data, 0);
  endtask

  // Monitor: pops expected writes and checks write/done timing.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        check_val("cs_eq_wr", mem_cs, mem_wr);
        if (mem_wr) begin
          check_val("wr_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val("wr_addr", mem_addr, mon_e.addr);
            check_val("wr_be", mem_be, mon_e.be);
            check_val("wr_data", mem_data, mon_e.data);
            check_val("wr_busy", load_busy, 1);
            check_val("wr_rdy_lo", pix_ready, 0);
            if (mon_e.be == 32'hFFFF_FFFF) last_data_cyc = cyc;
            else if (mon_e.data[7:0] == Marker) check_val("hdr_lat", cyc - last_data_cyc, 1);
          end
        end
        if (load_done) begin
          done_cnt++;
          check_val("done_lat", cyc - last_data_cyc, 2);
          done_cyc = cyc;
        end
        if (cyc == done_cyc + 1) check_val("busy_after_done", load_busy, 0);
      end
    end
  end

  // stop_after > 0 ends the load after that many accepted pixels, by abort or by reset.
  task automatic run_load(input bit gap, input int stop_after, input bit stop_rst,
                          input logic [23:0] seed);
    logic [767:0] grp_buf;
    int acc, g, since, budget, done0;
    bit stopped;
    grp_buf = '0;
    acc = 0; g = 0; since = -1; budget = 0; done0 = done_cnt; stopped = 1'b0;
    @(negedge clk);
    load_start = 1'b1;
`ifdef FAST_PAT_LOAD_CLR_HDR_EN
    push_wr(HdrAddr, 32'h1, 256'h0);
`endif
    @(negedge clk);
    load_start = 1'b0;
`ifdef FAST_PAT_LOAD_CLR_HDR_EN
    check_val("clr_rdy_lo", pix_ready, 0);
    @(negedge clk);
`endif
    check_val("start_rdy", pix_ready, 1);
    while (!stopped && acc < int'(Groups) * 32 && budget < 20000) begin
      if (since >= 0) begin
        since++;
        if (since <= 3) check_val("gap_rdy_lo", pix_ready, 0);
        else begin
          check_val("gap_rdy_hi", pix_ready, 1);
          since = -1;
        end
      end
      pix_valid = gap ? (budget % 2 == 0) : 1'b1;
      pix_data  = seed ^ 24'(acc);
      if (pix_valid && pix_ready) begin
        grp_buf[767 - 24 * (acc % 32) -: 24] = pix_data;
        acc++;
        if (acc % 32 == 0) begin
          for (int k = 0; k < 3; k++)
            push_wr(BaseAddr + 11'(3 * g + k), 32'hFFFF_FFFF, grp_buf[767 - 256 * k -: 256]);
          g++;
          if (g == int'(Groups)) push_wr(HdrAddr, 32'h1, {248'h0, Marker});
          else since = 0;
        end
        if (acc == stop_after) stopped = 1'b1;
      end
      budget++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    if (!stopped) begin
      check_val("all_accepted", acc, int'(Groups) * 32);
      budget = 0;
      while (done_cnt == done0 && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      check_val("done_pulse", done_cnt - done0, 1);
      repeat (2) @(negedge clk);
      check_val("sb_drained", exp_q.size(), 0);
    end else if (stop_rst) begin
      #2 rst_n = 1'b0;
      #1 check_zero("rst_mid");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      load_abort = 1'b1;
      @(negedge clk);
      load_abort = 1'b0;
      check_val("abort_no_wr", mem_wr, 0);
      check_val("abort_busy", load_busy, 0);
      check_val("abort_rdy", pix_ready, 0);
      repeat (3) @(negedge clk);
      check_val("abort_no_done", done_cnt - done0, 0);
      check_val("abort_sb_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_load(1'b0, -1, 1'b0, 24'h000000);
    run_load(1'b1, -1, 1'b0, 24'h000000);
    run_load(1'b0, 40, 1'b0, 24'h3c5a96);

    // Start and abort together in idle: nothing may happen.
    @(negedge clk);
    load_start = 1'b1;
    load_abort = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    load_abort = 1'b0;
    check_val("sa_busy", load_busy, 0);
    check_val("sa_wr", mem_wr, 0);
    check_val("sa_rdy", pix_ready, 0);
    @(negedge clk);
    check_val("sa_busy2", load_busy, 0);

    run_load(1'b0, 32, 1'b1, 24'hc0ffee);
    run_load(1'b1, -1, 1'b0, 24'h5a5a5a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
